noc_link_vchannel_mux: RTL and testbench

- Sits directly downstream of a compute tile's NoC output link (link_out_flit/last/valid/ready, one lane per virtual channel).
- Buffers each virtual channel in a small FIFO, then multiplexes the channels onto one shared physical flit bus towards the router.
- Arbitration is round-robin at packet granularity. A granted channel keeps the bus until its last flit transfers.
- The one-hot valid vector tells the router which virtual channel owns the current flit.

---
 rtl/noc_link_vchannel_mux.sv | 113 +++++++++++
 tb/tb_noc_link_vchannel_mux.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_link_vchannel_mux.sv
// rtl/noc_link_vchannel_mux.sv - per-virtual-channel FIFOs muxed onto one physical flit bus
// Round-robin arbitration at packet granularity; the granted channel owns the bus until its last flit.
module noc_link_vchannel_mux #(
   parameter int CHANNELS   = 2,
   parameter int FLIT_WIDTH = 34,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CHANNELS*FLIT_WIDTH-1:0] link_in_flit,
   input  logic [CHANNELS-1:0]            link_in_last,
   input  logic [CHANNELS-1:0]            link_in_valid,
   output logic [CHANNELS-1:0]            link_in_ready,
   output logic [FLIT_WIDTH-1:0]          link_out_flit,
   output logic                           link_out_last,
   output logic [CHANNELS-1:0]            link_out_valid,
   input  logic [CHANNELS-1:0]            link_out_ready
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                               state, state_nxt;
   logic [CW-1:0]                        cur, cur_nxt;
   logic [CW-1:0]                        rr_ptr, rr_nxt;
   logic [CW-1:0]                        scan_idx;
   logic [CHANNELS-1:0][PW-1:0]          count;
   logic [CHANNELS-1:0][FLIT_WIDTH:0]    heads;
   logic [CHANNELS-1:0]                  not_empty;
   logic [CHANNELS-1:0]                  push;
   logic [CHANNELS-1:0]                  pop;
   logic [FLIT_WIDTH:0]                  head;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [FLIT_WIDTH:0] mem [FIFO_DEPTH];
      logic [PW-1:0]       wr_ptr;
      logic [PW-1:0]       rd_ptr;

      // Pointers carry one extra bit so full and empty are distinguishable.
      assign count[c]         = wr_ptr - rd_ptr;
      assign not_empty[c]     = (count[c] != '0);
      assign link_in_ready[c] = rst & (count[c] != DEPTH_P);
      assign push[c]          = link_in_valid[c] & link_in_ready[c];
      assign heads[c]         = mem[rd_ptr[AW-1:0]];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push[c]) wr_ptr <= wr_ptr + 1'b1;
            if (pop[c])  rd_ptr <= rd_ptr + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (push[c]) mem[wr_ptr[AW-1:0]] <= {link_in_last[c], link_in_flit[c*FLIT_WIDTH +: FLIT_WIDTH]};
      end
   end

   assign head = heads[cur];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cur    <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         cur    <= cur_nxt;
         rr_ptr <= rr_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cur_nxt        = cur;
      rr_nxt         = rr_ptr;
      scan_idx       = '0;
      pop            = '0;
      link_out_valid = '0;
      link_out_flit  = '0;
      link_out_last  = 1'b0;
      case (state)
         IDLE: begin
            if (|not_empty) state_nxt = ACTIVE;
            // Scan downwards so the channel closest to rr_ptr is the last one written.
            for (int i = CHANNELS - 1; i >= 0; i--) begin
               scan_idx = CW'((int'(rr_ptr) + i) % CHANNELS);
               if (not_empty[scan_idx]) cur_nxt = scan_idx;
            end
         end
         ACTIVE: begin
            // The lock is kept even when the FIFO drains mid-packet.
            if (not_empty[cur]) begin
               link_out_valid[cur] = 1'b1;
               link_out_flit       = head[FLIT_WIDTH-1:0];
               link_out_last       = head[FLIT_WIDTH];
               if (link_out_ready[cur]) begin
                  pop[cur] = 1'b1;
                  if (head[FLIT_WIDTH]) begin
                     state_nxt = IDLE;
                     rr_nxt    = (cur == CW'(CHANNELS - 1)) ? '0 : cur + 1'b1;
                  end
               end
            end
         end
      endcase
   end
endmodule

// File: tb/tb_noc_link_vchannel_mux.sv
// tb/tb_noc_link_vchannel_mux.sv - scenario tasks plus randomized traffic against a queue-level model
module tb_noc_link_vchannel_mux;
   localparam int CH    = 2;
   localparam int FW    = 34;
   localparam int DEPTH = 4;

   logic              clk;
   logic              rst;
   logic [CH*FW-1:0]  link_in_flit;
   logic [CH-1:0]     link_in_last;
   logic [CH-1:0]     link_in_valid;
   logic [CH-1:0]     link_in_ready;
   logic [FW-1:0]     link_out_flit;
   logic              link_out_last;
   logic [CH-1:0]     link_out_valid;
   logic [CH-1:0]     link_out_ready;

   noc_link_vchannel_mux #(.CHANNELS(CH), .FLIT_WIDTH(FW), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .link_in_flit  (link_in_flit),
      .link_in_last  (link_in_last),
      .link_in_valid (link_in_valid),
      .link_in_ready (link_in_ready),
      .link_out_flit (link_out_flit),
      .link_out_last (link_out_last),
      .link_out_valid(link_out_valid),
      .link_out_ready(link_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: buffered flits per channel, bus owner (-1 = none), next channel to favour.
   logic [FW:0] q   [CH][$];
   logic [FW:0] src [CH][$];
   int          owner = -1;
   int          rr    = 0;
   int          xfer_ch;
   logic [CH-1:0] rdy_mask;
   bit          gaps;
   bit          rand_rdy;
   logic [CH-1:0] exp_valid, exp_ready;
   logic [FW-1:0] exp_flit;
   logic          exp_last;

   function automatic logic [FW:0] mk(input logic last, input logic [FW-1:0] v);
      return {last, v};
   endfunction

   function automatic bit idle();
      bit r = (owner < 0);
      for (int c = 0; c < CH; c++) if (q[c].size() != 0 || src[c].size() != 0) r = 0;
      return r;
   endfunction

   function automatic int dut_xfer();
      int r = -1;
      for (int c = 0; c < CH; c++) if (link_out_valid[c] && link_out_ready[c]) r = c;
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         q[c].delete();
         src[c].delete();
      end
      owner = -1;
      rr    = 0;
   endtask

   task automatic set_inputs();
      for (int c = 0; c < CH; c++) begin
         link_in_valid[c] = (src[c].size() != 0) && (!gaps || $urandom_range(0, 3) != 0);
         link_in_flit[c*FW +: FW] = link_in_valid[c] ? src[c][0][FW-1:0] : '0;
         link_in_last[c] = link_in_valid[c] ? src[c][0][FW] : 1'b0;
      end
      link_out_ready = rand_rdy ? (rdy_mask & CH'($urandom)) : rdy_mask;
   endtask

   task automatic model_expect();
      exp_valid = '0;
      exp_flit  = '0;
      exp_last  = 1'b0;
      for (int c = 0; c < CH; c++) exp_ready[c] = rst && (q[c].size() < DEPTH);
      if (owner >= 0 && q[owner].size() != 0) begin
         exp_valid[owner] = 1'b1;
         exp_flit = q[owner][0][FW-1:0];
         exp_last = q[owner][0][FW];
      end
   endtask

   // Applies what the coming clock edge does: transfer or grant, then tile pushes.
   task automatic model_commit();
      int pick = -1;
      logic [FW:0] f;
      xfer_ch = -1;
      for (int i = 0; i < CH; i++)
         if (pick < 0 && q[(rr + i) % CH].size() != 0) pick = (rr + i) % CH;
      if (owner >= 0 && exp_valid[owner] && link_out_ready[owner]) begin
         xfer_ch = owner;
         f = q[owner].pop_front();
         if (f[FW]) begin
            rr    = (owner + 1) % CH;
            owner = -1;
         end
      end else if (owner < 0 && pick >= 0) begin
         owner = pick;
      end
      for (int c = 0; c < CH; c++)
         if (link_in_valid[c] && exp_ready[c]) q[c].push_back(src[c].pop_front());
   endtask

   task automatic begin_cycle();
      @(negedge clk);
      set_inputs();
      model_expect();
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      link_in_valid = '0;
      repeat (2) @(negedge clk);
      model_reset();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      link_in_valid = '1;
      link_in_flit = '1;
      link_in_last = '1;
      link_out_ready = '1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got rdy=%b vld=%b last=%b flit=%h want all zero", link_in_ready, link_out_valid, link_out_last, link_out_flit);
      end
      model_reset();
      link_in_valid = '0;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({link_in_ready, link_out_valid} !== {2'b11, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_release got rdy=%b vld=%b want rdy=11 vld=00", link_in_ready, link_out_valid);
      end
   endtask

   task automatic test_single_packet();
      logic [CH-1:0] dv;
      logic [FW-1:0] df;
      logic          dl;
      src[0].push_back(mk(1'b0, 'h1));
      src[0].push_back(mk(1'b0, 'h2));
      src[0].push_back(mk(1'b1, 'h3));
      for (int k = 0; k < 8; k++) begin
         begin_cycle();
         n_checks++;
         if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== {exp_ready, exp_valid, exp_last, exp_flit}) begin
            n_fail++;
            $display("FAIL single_model k=%0d got rdy=%b vld=%b last=%b flit=%h want rdy=%b vld=%b last=%b flit=%h", k, link_in_ready, link_out_valid, link_out_last, link_out_flit, exp_ready, exp_valid, exp_last, exp_flit);
         end
         dv = (k >= 2 && k <= 4) ? 2'b01 : 2'b00;
         df = (k >= 2 && k <= 4) ? FW'(k - 1) : '0;
         dl = (k == 4);
         n_checks++;
         if ({link_out_valid, link_out_last, link_out_flit} !== {dv, dl, df}) begin
            n_fail++;
            $display("FAIL single_timing k=%0d got vld=%b last=%b flit=%h want vld=%b last=%b flit=%h", k, link_out_valid, link_out_last, link_out_flit, dv, dl, df);
         end
         model_commit();
      end
   endtask

   task automatic test_two_channels();
      string got = "";
      int c;
      apply_reset();
      for (int r = 0; r < 2; r++) begin
         src[0].push_back(mk(1'b0, FW'('h10 + r)));
         src[0].push_back(mk(1'b1, FW'('h11 + r)));
         src[1].push_back(mk(1'b0, FW'('h20 + r)));
         src[1].push_back(mk(1'b1, FW'('h21 + r)));
         for (int k = 0; k < 40 && !idle(); k++) begin
            begin_cycle();
            n_checks++;
            if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== {exp_ready, exp_valid, exp_last, exp_flit}) begin
               n_fail++;
               $display("FAIL two_ch_model r=%0d k=%0d got rdy=%b vld=%b last=%b flit=%h want rdy=%b vld=%b last=%b flit=%h", r, k, link_in_ready, link_out_valid, link_out_last, link_out_flit, exp_ready, exp_valid, exp_last, exp_flit);
            end
            c = dut_xfer();
            if (c >= 0) got = {got, $sformatf("%0d", c)};
            model_commit();
         end
      end
      n_checks++;
      if (got != "00110011") begin
         n_fail++;
         $display("FAIL two_ch_order got=%s want=00110011", got);
      end
   endtask

   task automatic test_fill();
      string got = "";
      rdy_mask = 2'b01;
      for (int i = 0; i < 5; i++) src[1].push_back(mk(i >= 3, FW'('h40 + i)));
      for (int k = 0; k < 8; k++) begin
         begin_cycle();
         n_checks++;
         if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== {exp_ready, exp_valid, exp_last, exp_flit}) begin
            n_fail++;
            $display("FAIL fill_model k=%0d got rdy=%b vld=%b last=%b flit=%h want rdy=%b vld=%b last=%b flit=%h", k, link_in_ready, link_out_valid, link_out_last, link_out_flit, exp_ready, exp_valid, exp_last, exp_flit);
         end
         model_commit();
      end
      #2;
      n_checks++;
      if (link_in_ready[1] !== 1'b0 || link_in_valid[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_full got ready1=%b valid1=%b want ready1=0 valid1=1", link_in_ready[1], link_in_valid[1]);
      end
      rdy_mask = 2'b11;
      for (int k = 0; k < 40 && !idle(); k++) begin
         begin_cycle();
         n_checks++;
         if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== {exp_ready, exp_valid, exp_last, exp_flit}) begin
            n_fail++;
            $display("FAIL fill_drain_model k=%0d got rdy=%b vld=%b last=%b flit=%h want rdy=%b vld=%b last=%b flit=%h", k, link_in_ready, link_out_valid, link_out_last, link_out_flit, exp_ready, exp_valid, exp_last, exp_flit);
         end
         if (dut_xfer() == 1) got = {got, $sformatf("%0h ", link_out_flit)};
         model_commit();
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (got != "40 41 42 43 44 " || link_in_ready !== 2'b11) begin
         n_fail++;
         $display("FAIL fill_drain got order=%s ready=%b want order=40 41 42 43 44 ready=11", got, link_in_ready);
      end
   endtask

   task automatic test_stall();
      string got = "";
      int c;
      rdy_mask = 2'b11;
      src[0].push_back(mk(1'b0, 'hA));
      for (int ph = 0; ph < 3; ph++) begin
         if (ph == 1) begin
            src[1].push_back(mk(1'b0, 'h50));
            src[1].push_back(mk(1'b1, 'h51));
         end
         if (ph == 2) src[0].push_back(mk(1'b1, 'hB));
         for (int k = 0; k < ((ph == 2) ? 40 : 3) && (ph != 2 || !idle()); k++) begin
            begin_cycle();
            n_checks++;
            if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== {exp_ready, exp_valid, exp_last, exp_flit}) begin
               n_fail++;
               $display("FAIL stall_model ph=%0d k=%0d got rdy=%b vld=%b last=%b flit=%h want rdy=%b vld=%b last=%b flit=%h", ph, k, link_in_ready, link_out_valid, link_out_last, link_out_flit, exp_ready, exp_valid, exp_last, exp_flit);
            end
            if (ph == 1) begin
               n_checks++;
               if (link_out_valid !== 2'b00) begin
                  n_fail++;
                  $display("FAIL stall_hold k=%0d got vld=%b want 00", k, link_out_valid);
               end
            end
            c = dut_xfer();
            if (c >= 0) got = {got, $sformatf("%0d:%0h ", c, link_out_flit)};
            model_commit();
         end
      end
      n_checks++;
      if (got != "0:a 0:b 1:50 1:51 ") begin
         n_fail++;
         $display("FAIL stall_order got=%s want=0:a 0:b 1:50 1:51", got);
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      rdy_mask = 2'b10;
      src[0].push_back(mk(1'b1, 'h2A5));
      for (int k = 0; k < 13; k++) begin
         if (k == 7) rdy_mask = 2'b11;
         begin_cycle();
         n_checks++;
         if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== {exp_ready, exp_valid, exp_last, exp_flit}) begin
            n_fail++;
            $display("FAIL bp_model k=%0d got rdy=%b vld=%b last=%b flit=%h want rdy=%b vld=%b last=%b flit=%h", k, link_in_ready, link_out_valid, link_out_last, link_out_flit, exp_ready, exp_valid, exp_last, exp_flit);
         end
         if (k >= 2 && k <= 6) begin
            n_checks++;
            if ({link_out_valid, link_out_last, link_out_flit} !== {2'b01, 1'b1, FW'('h2A5)}) begin
               n_fail++;
               $display("FAIL bp_hold k=%0d got vld=%b last=%b flit=%h want vld=01 last=1 flit=2a5", k, link_out_valid, link_out_last, link_out_flit);
            end
         end
         if (dut_xfer() >= 0) n++;
         model_commit();
      end
      n_checks++;
      if (n != 1) begin
         n_fail++;
         $display("FAIL bp_release got %0d transfers want 1", n);
      end
   endtask

   task automatic test_reset_mid();
      string got = "";
      int c;
      int nx = 0;
      rdy_mask = 2'b11;
      src[0].push_back(mk(1'b1, 'h5F));
      for (int i = 0; i < 4; i++) src[0].push_back(mk(i == 3, FW'('h60 + i)));
      for (int k = 0; k < 30 && nx < 3; k++) begin
         begin_cycle();
         n_checks++;
         if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== {exp_ready, exp_valid, exp_last, exp_flit}) begin
            n_fail++;
            $display("FAIL rmid_model k=%0d got rdy=%b vld=%b last=%b flit=%h want rdy=%b vld=%b last=%b flit=%h", k, link_in_ready, link_out_valid, link_out_last, link_out_flit, exp_ready, exp_valid, exp_last, exp_flit);
         end
         model_commit();
         if (xfer_ch >= 0) nx++;
      end
      @(negedge clk);
      #2;
      rst = 1'b0;
      link_in_valid = '0;
      #1;
      n_checks++;
      if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== '0) begin
         n_fail++;
         $display("FAIL rmid_async got rdy=%b vld=%b last=%b flit=%h want all zero", link_in_ready, link_out_valid, link_out_last, link_out_flit);
      end
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      src[0].push_back(mk(1'b1, 'h70));
      src[1].push_back(mk(1'b1, 'h80));
      for (int k = 0; k < 30 && !idle(); k++) begin
         begin_cycle();
         n_checks++;
         if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== {exp_ready, exp_valid, exp_last, exp_flit}) begin
            n_fail++;
            $display("FAIL rmid_after_model k=%0d got rdy=%b vld=%b last=%b flit=%h want rdy=%b vld=%b last=%b flit=%h", k, link_in_ready, link_out_valid, link_out_last, link_out_flit, exp_ready, exp_valid, exp_last, exp_flit);
         end
         c = dut_xfer();
         if (c >= 0) got = {got, $sformatf("%0d:%0h ", c, link_out_flit)};
         model_commit();
      end
      n_checks++;
      if (got != "0:70 1:80 ") begin
         n_fail++;
         $display("FAIL rmid_after_order got=%s want=0:70 1:80", got);
      end
   endtask

   task automatic test_random();
      int len;
      gaps = 1;
      rand_rdy = 1;
      rdy_mask = 2'b11;
      for (int k = 0; k < 800; k++) begin
         if (k < 300) begin
            for (int c = 0; c < CH; c++) begin
               if (src[c].size() < 4 && $urandom_range(0, 3) == 0) begin
                  len = $urandom_range(1, 4);
                  for (int i = 0; i < len; i++) src[c].push_back(mk(i == len - 1, FW'({$urandom, $urandom})));
               end
            end
         end else if (idle()) begin
            break;
         end
         begin_cycle();
         n_checks++;
         if ({link_in_ready, link_out_valid, link_out_last, link_out_flit} !== {exp_ready, exp_valid, exp_last, exp_flit}) begin
            n_fail++;
            $display("FAIL random_model k=%0d got rdy=%b vld=%b last=%b flit=%h want rdy=%b vld=%b last=%b flit=%h", k, link_in_ready, link_out_valid, link_out_last, link_out_flit, exp_ready, exp_valid, exp_last, exp_flit);
         end
         model_commit();
      end
      n_checks++;
      if (!idle()) begin
         n_fail++;
         $display("FAIL random_drain got traffic still pending want idle within budget");
      end
   endtask

   initial begin
      rst = 1'b0;
      link_in_flit = '0;
      link_in_last = '0;
      link_in_valid = '0;
      link_out_ready = '0;
      rdy_mask = 2'b11;
      gaps = 0;
      rand_rdy = 0;
      test_reset();
      test_single_packet();
      test_two_channels();
      test_fill();
      test_stall();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
